// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
// Shared definitions for the IF-stage fetch sequencer:
//   ZERO_WORD         - all-zero 32-bit word used for cleared outputs
//   RESET_PC_DEFAULT  - default PC loaded on reset
//   PC_STEP_DEFAULT   - default sequential PC increment
//   fetch_state_e     - fetch FSM states {IDLE, REQ, WAIT, HOLD}
//   pend_type_e       - pending redirect kind {PEND_NONE, PEND_BR, PEND_FL}
//   pc_misaligned()   - word-alignment check on the low PC bits
// ---------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_BR   = 2'd1,
        PEND_FL   = 2'd2
    } pend_type_e;

    // Instruction fetches must be word aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_mux.sv
// ---------------------------------------------------------------------------
// next_pc_mux
// Combinational priority select of the next fetch PC:
//   live flush > pending flush > pending branch > live branch > pc + PC_STEP
// Ports:
//   flush, flush_pc         - flush redirect presented this cycle
//   pend_type, pend_pc      - redirect latched earlier and not yet consumed
//   branch, branch_pc       - branch redirect presented this cycle
//   pc                      - current fetch PC
//   next_pc                 - selected next PC (sequential path wraps mod 2^32)
// ---------------------------------------------------------------------------
module next_pc_mux
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
    input  logic       flush,
    input  logic [31:0] flush_pc,
    input  pend_type_e pend_type,
    input  logic [31:0] pend_pc,
    input  logic       branch,
    input  logic [31:0] branch_pc,
    input  logic [31:0] pc,
    output logic [31:0] next_pc
);

    // Priority redirect select; a pending branch was resolved before any
    // live one, so it is the one that belongs to this PC update.
    always_comb begin
        next_pc = pc + PC_STEP;
        if (flush) begin
            next_pc = flush_pc;
        end else if (pend_type == PEND_FL) begin
            next_pc = pend_pc;
        end else if (pend_type == PEND_BR) begin
            next_pc = pend_pc;
        end else if (branch) begin
            next_pc = branch_pc;
        end else begin
            next_pc = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// IF-stage fetch sequencer. Owns the fetch PC, runs a single-outstanding
// SRAM-like request/addr_ok/data_ok handshake and delivers {pc, inst} to ID
// with stall back-pressure. Branches are deferred (delay slot is delivered);
// flushes cancel the in-flight fetch.
// Optional feature macro: IF_ADEL_CHECK_EN - a misaligned PC issues no
// request and instead delivers an address-error marker (adel_o=1, inst_o=0).
// Without the macro adel_o is constant 0.
// Ports:
//   clk_i, rst_i                 - clock, asynchronous active-high reset
//   stall_i                      - ID not ready, hold delivered instruction
//   flush_i, flush_pc_i          - exception/ERET redirect
//   branch_i, branch_pc_i        - taken branch/jump resolved in ID
//   inst_req_o, inst_addr_o      - memory request and address
//   inst_addr_ok_i               - address accepted
//   inst_data_ok_i, inst_rdata_i - read data returned
//   inst_valid_o, pc_o, inst_o   - delivered instruction to ID
//   adel_o                       - fetch address error
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_i,
    input  logic [31:0] branch_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        adel_o
);

    fetch_state_e state_r,     state_nx_s;
    pend_type_e   pend_type_r, pend_type_nx_s;
    logic [31:0]  pc_r,        pc_nx_s;
    logic [31:0]  pend_pc_r,   pend_pc_nx_s;
    logic [31:0]  hold_inst_r, hold_inst_nx_s;
    logic         cancel_r,    cancel_nx_s;
    logic         adel_r,      adel_nx_s;
    logic [31:0]  next_pc_s;
    logic         pc_load_s;
    logic         misaligned_s;
    logic         req_s;
    logic         valid_s;
    logic [31:0]  pc_out_s;
    logic [31:0]  inst_out_s;
    logic         adel_out_s;

    next_pc_mux #(
        .PC_STEP   (PC_STEP)
    ) u_next_pc_mux (
        .flush     (flush_i),
        .flush_pc  (flush_pc_i),
        .pend_type (pend_type_r),
        .pend_pc   (pend_pc_r),
        .branch    (branch_i),
        .branch_pc (branch_pc_i),
        .pc        (pc_r),
        .next_pc   (next_pc_s)
    );

    // Alignment check; without the feature every PC is treated as aligned,
    // so adel_r can never be set and adel_o stays 0.
    always_comb begin
`ifdef IF_ADEL_CHECK_EN
        misaligned_s = pc_misaligned(pc_r[1:0]);
`else
        misaligned_s = 1'b0;
`endif
    end

    // Fetch FSM next-state, handshake outputs and pending-redirect tracking.
    always_comb begin
        state_nx_s     = state_r;
        pc_nx_s        = pc_r;
        pend_type_nx_s = pend_type_r;
        pend_pc_nx_s   = pend_pc_r;
        cancel_nx_s    = cancel_r;
        hold_inst_nx_s = hold_inst_r;
        adel_nx_s      = adel_r;
        pc_load_s      = 1'b0;
        req_s          = 1'b0;
        valid_s        = 1'b0;
        pc_out_s       = ZERO_WORD;
        inst_out_s     = ZERO_WORD;
        adel_out_s     = 1'b0;

        case (state_r)
            IDLE: begin
                state_nx_s = REQ;
                pc_load_s  = flush_i;
            end
            REQ: begin
                if (misaligned_s) begin
                    // No bus traffic: redirect at once on flush, otherwise
                    // present the address-error marker from HOLD.
                    if (flush_i) begin
                        pc_load_s = 1'b1;
                    end else begin
                        state_nx_s     = HOLD;
                        hold_inst_nx_s = ZERO_WORD;
                        adel_nx_s      = 1'b1;
                    end
                end else begin
                    req_s = 1'b1;
                    if (inst_addr_ok_i) begin
                        // A flush seen during the request cancels the data.
                        state_nx_s  = WAIT;
                        cancel_nx_s = flush_i | (pend_type_r == PEND_FL);
                    end else begin
                        state_nx_s = REQ;
                    end
                end
            end
            WAIT: begin
                if (inst_data_ok_i) begin
                    if (cancel_r | flush_i) begin
                        pc_load_s   = 1'b1;
                        cancel_nx_s = 1'b0;
                        state_nx_s  = REQ;
                    end else begin
                        // Data is forwarded to ID in the cycle it returns.
                        valid_s    = 1'b1;
                        pc_out_s   = pc_r;
                        inst_out_s = inst_rdata_i;
                        if (stall_i) begin
                            hold_inst_nx_s = inst_rdata_i;
                            adel_nx_s      = 1'b0;
                            state_nx_s     = HOLD;
                        end else begin
                            pc_load_s  = 1'b1;
                            state_nx_s = REQ;
                        end
                    end
                end else begin
                    cancel_nx_s = cancel_r | flush_i;
                end
            end
            HOLD: begin
                valid_s    = 1'b1;
                pc_out_s   = pc_r;
                inst_out_s = hold_inst_r;
                adel_out_s = adel_r;
                if (flush_i | ~stall_i) begin
                    pc_load_s  = 1'b1;
                    adel_nx_s  = 1'b0;
                    state_nx_s = REQ;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase

        // A PC update consumes any redirect; otherwise latch the new one.
        // A flush overrides a pending branch; a branch never overrides a flush.
        if (pc_load_s) begin
            pc_nx_s        = next_pc_s;
            pend_type_nx_s = PEND_NONE;
            pend_pc_nx_s   = ZERO_WORD;
        end else if (flush_i) begin
            pend_type_nx_s = PEND_FL;
            pend_pc_nx_s   = flush_pc_i;
        end else if (branch_i && (pend_type_r != PEND_FL)) begin
            pend_type_nx_s = PEND_BR;
            pend_pc_nx_s   = branch_pc_i;
        end else begin
            pend_type_nx_s = pend_type_r;
            pend_pc_nx_s   = pend_pc_r;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            pend_type_r <= PEND_NONE;
            pend_pc_r   <= ZERO_WORD;
            cancel_r    <= 1'b0;
            hold_inst_r <= ZERO_WORD;
            adel_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            pc_r        <= pc_nx_s;
            pend_type_r <= pend_type_nx_s;
            pend_pc_r   <= pend_pc_nx_s;
            cancel_r    <= cancel_nx_s;
            hold_inst_r <= hold_inst_nx_s;
            adel_r      <= adel_nx_s;
        end
    end

    assign inst_req_o   = req_s;
    assign inst_addr_o  = pc_r;
    assign inst_valid_o = valid_s;
    assign pc_o         = pc_out_s;
    assign inst_o       = inst_out_s;
    assign adel_o       = adel_out_s;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Scoreboard bench for pc_fetch_ctrl. Expected request addresses and
// delivered PCs are queued up front; monitors pop and compare on every
// accepted request and every consumed delivery. A small memory responder
// accepts addresses the same cycle and returns ~addr the next cycle.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        branch = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        adel;

    logic        addr_en = 1'b1;
    logic        data_en = 1'b1;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_del_q[$];

    logic        prev_req_wait = 1'b0;
    logic [31:0] prev_req_addr = 32'h0;

    pc_fetch_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .flush_pc_i     (flush_pc),
        .branch_i       (branch),
        .branch_pc_i    (branch_pc),
        .inst_req_o     (inst_req),
        .inst_addr_o    (inst_addr),
        .inst_addr_ok_i (inst_addr_ok),
        .inst_data_ok_i (inst_data_ok),
        .inst_rdata_i   (inst_rdata),
        .inst_valid_o   (inst_valid),
        .pc_o           (pc_out),
        .inst_o         (inst_out),
        .adel_o         (adel)
    );

    always #5 clk = ~clk;

    // Memory responder: addr_ok in the request cycle, data one cycle later.
    assign inst_addr_ok = inst_req & addr_en;
    assign inst_data_ok = mem_pend & data_en;
    assign inst_rdata   = inst_data_ok ? ~mem_addr : 32'h0;

    always @(posedge clk) begin
        if (inst_req && inst_addr_ok) begin
            mem_pend <= 1'b1;
            mem_addr <= inst_addr;
        end else if (inst_data_ok) begin
            mem_pend <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: request addresses, request stability, consumed deliveries.
    always @(negedge clk) begin
        logic [31:0] e;
        if (prev_req_wait) begin
            chk("req_held", {31'd0, inst_req}, 32'd1);
            chk("req_addr_stable", inst_addr, prev_req_addr);
        end
        prev_req_wait = inst_req && !inst_addr_ok;
        prev_req_addr = inst_addr;
        if (inst_req && inst_addr_ok) begin
            if (exp_req_q.size() == 0) begin
                chk("unexpected_req", inst_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_req_q.pop_front();
                chk("req_addr", inst_addr, e);
            end
        end
        if (inst_valid && !stall) begin
            if (exp_del_q.size() == 0) begin
                chk("unexpected_valid_pc", pc_out, 32'hFFFF_FFFF);
            end else begin
                e = exp_del_q.pop_front();
                chk("del_pc", pc_out, e);
                chk("del_inst", inst_out, ~e);
                chk("del_adel", {31'd0, adel}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (inst_req === 1'b1 && inst_addr === a) found = 1'b1;
        end
        chk($sformatf("wait_req_%h", a), {31'd0, found}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_req_q = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100,
                      32'hBFC0_0104, 32'hBFC0_0380, 32'hBFC0_0384, 32'hBFC0_0380,
                      32'hBFC0_0384, 32'hBFC0_0000, 32'hBFC0_0004};
        exp_del_q = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100,
                      32'hBFC0_0380, 32'hBFC0_0380, 32'hBFC0_0000};

        // Reset state.
        tick();
        tick();
        @(negedge clk);
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc_o", pc_out, 32'h0);
        chk("rst_inst_o", inst_out, 32'h0);
        chk("rst_adel", {31'd0, adel}, 32'd0);
        tick();
        rst = 1'b0;

        // Stall three cycles on the instruction at 0xBFC00004.
        wait_req(32'hBFC0_0004);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_pc", pc_out, 32'hBFC0_0004);
            chk("stall_inst", inst_out, ~32'hBFC0_0004);
            chk("stall_no_req", {31'd0, inst_req}, 32'd0);
            tick();
        end
        stall = 1'b0;

        // Branch while 0xBFC00008 is in WAIT: delay slot delivered.
        wait_req(32'hBFC0_0008);
        tick();
        branch    = 1'b1;
        branch_pc = 32'hBFC0_0100;
        tick();
        branch = 1'b0;
        wait_req(32'hBFC0_0100);

        // Flush in WAIT: data for 0xBFC00104 discarded.
        wait_req(32'hBFC0_0104);
        tick();
        data_en  = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0380;
        tick();
        flush   = 1'b0;
        data_en = 1'b1;
        wait_req(32'hBFC0_0380);

        // Flush together with branch: flush target wins.
        wait_req(32'hBFC0_0384);
        tick();
        data_en   = 1'b0;
        flush     = 1'b1;
        flush_pc  = 32'hBFC0_0380;
        branch    = 1'b1;
        branch_pc = 32'hBFC0_0200;
        tick();
        flush   = 1'b0;
        branch  = 1'b0;
        data_en = 1'b1;
        wait_req(32'hBFC0_0380);

        // Reset during WAIT, then a stray data_ok in IDLE.
        wait_req(32'hBFC0_0384);
        tick();
        data_en = 1'b0;
        tick();
        stall   = 1'b1;
        data_en = 1'b1;
        #1;
        chk("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
        chk("pre_rst_pc", pc_out, 32'hBFC0_0384);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("async_rst_pc", pc_out, 32'h0);
        chk("async_rst_inst", inst_out, 32'h0);
        chk("async_rst_req", {31'd0, inst_req}, 32'd0);
        data_en = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        data_en = 1'b1;
        stall   = 1'b0;
        @(negedge clk);
        chk("stray_data_valid", {31'd0, inst_valid}, 32'd0);
        chk("stray_data_req", {31'd0, inst_req}, 32'd0);
        wait_req(32'hBFC0_0000);

        // Final flush in WAIT, then stop the memory.
        wait_req(32'hBFC0_0004);
        tick();
        data_en = 1'b0;
        stall   = 1'b1;
        flush   = 1'b1;
        addr_en = 1'b0;
`ifdef IF_ADEL_CHECK_EN
        flush_pc = 32'hBFC0_0382;
`else
        flush_pc = 32'hBFC0_0388;
`endif
        tick();
        flush   = 1'b0;
        data_en = 1'b1;
        @(negedge clk);
        chk("final_discard_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        @(negedge clk);
`ifdef IF_ADEL_CHECK_EN
        chk("adel_no_req", {31'd0, inst_req}, 32'd0);
        tick();
        @(negedge clk);
        chk("adel_valid", {31'd0, inst_valid}, 32'd1);
        chk("adel_flag", {31'd0, adel}, 32'd1);
        chk("adel_pc", pc_out, 32'hBFC0_0382);
        chk("adel_inst", inst_out, 32'h0);
        chk("adel_still_no_req", {31'd0, inst_req}, 32'd0);
`else
        chk("final_req", {31'd0, inst_req}, 32'd1);
        chk("final_addr", inst_addr, 32'hBFC0_0388);
        tick();
        @(negedge clk);
        chk("final_req_held", {31'd0, inst_req}, 32'd1);
        chk("final_addr_held", inst_addr, 32'hBFC0_0388);
        chk("final_no_valid", {31'd0, inst_valid}, 32'd0);
        chk("final_adel", {31'd0, adel}, 32'd0);
`endif
        tick();
        tick();
        chk("req_queue_left", exp_req_q.size(), 32'd0);
        chk("del_queue_left", exp_del_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
